// File: rtl/macs_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : macs_ctrl
// Purpose  : Operand sequencer for the four-lane Macs multiply-accumulate
//            array. Fetches cfg_len operand pairs, issues them one at a time
//            with the running accumulator as C, and presents the final
//            1x4 row tile (E +/- A*B, or E + B[0]) on a valid/ready port.
// Options  : MACS_CTRL_WDOG_EN - adds a 32-cycle watchdog on mac_valid that
//            parks the FSM in ERR (exit only via rst).
// Revision : 1.0 - initial release
// ============================================================================
module macs_ctrl #(
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_mode,
   input  logic             cfg_neg,
   input  logic [63:0]      e_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             rd_en,
   output logic [LEN_W-1:0] rd_addr,
   input  logic [15:0]      a_data,
   input  logic [63:0]      b_data,
   output logic             mac_en,
   output logic             mac_mode,
   output logic             mac_signal,
   output logic [15:0]      mac_a,
   output logic [63:0]      mac_b,
   output logic [63:0]      mac_c,
   input  logic             mac_valid,
   input  logic [63:0]      mac_result,
   output logic             res_valid,
   output logic [63:0]      res_data,
   input  logic             res_ready
);

`ifdef MACS_CTRL_WDOG_EN
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      LD    = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      OUT   = 3'd5,
      ERR   = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      LD    = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      OUT   = 3'd5
   } state_t;
`endif

   state_t           state;
   logic [LEN_W-1:0] len_q;    // latched inner dimension N
   logic [LEN_W-1:0] k;        // index of the element currently in flight
   logic [63:0]      acc;      // running accumulator, seeded from e_data
   logic [LEN_W-1:0] k_next;

   assign k_next = k + LEN_W'(1);

   // The handshake cycle itself is the done cycle, so done is a pure AND of
   // the registered valid with the downstream ready.
   assign done = res_valid & res_ready;

`ifdef MACS_CTRL_WDOG_EN
   logic [4:0] wdog;           // WAIT cycles elapsed without mac_valid
`else
   assign err = 1'b0;
`endif

   // Tile sequencer: single FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         len_q      <= '0;
         k          <= '0;
         acc        <= '0;
         busy       <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         mac_en     <= 1'b0;
         mac_mode   <= 1'b0;
         mac_signal <= 1'b0;
         mac_a      <= '0;
         mac_b      <= '0;
         mac_c      <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
`ifdef MACS_CTRL_WDOG_EN
         wdog       <= '0;
         err        <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle; each state that needs one re-arms it.
         rd_en  <= 1'b0;
         mac_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q      <= cfg_len;
                  mac_mode   <= cfg_mode;
                  mac_signal <= cfg_neg;
                  acc        <= e_data;
                  k          <= '0;
                  busy       <= 1'b1;
                  // A zero-length matmul has nothing to issue: the seed is the
                  // answer. Matadd always issues element 0.
                  if (!cfg_mode && (cfg_len == '0)) begin
                     res_valid <= 1'b1;
                     res_data  <= e_data;
                     state     <= OUT;
                  end else begin
                     rd_en   <= 1'b1;
                     rd_addr <= '0;
                     state   <= RD;
                  end
               end
            end
            RD: begin
               state <= LD;
            end
            LD: begin
               // Operands land from the RAMs this cycle; freeze them together
               // with the accumulator so they hold from ISSUE through WAIT.
               mac_a  <= a_data;
               mac_b  <= b_data;
               mac_c  <= acc;
               mac_en <= 1'b1;
               state  <= ISSUE;
            end
            ISSUE: begin
`ifdef MACS_CTRL_WDOG_EN
               wdog  <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (mac_valid) begin
                  acc <= mac_result;
                  k   <= k_next;
                  if (mac_mode || (k_next == len_q)) begin
                     res_valid <= 1'b1;
                     res_data  <= mac_result;
                     state     <= OUT;
                  end else begin
                     rd_en   <= 1'b1;
                     rd_addr <= k_next;
                     state   <= RD;
                  end
               end
`ifdef MACS_CTRL_WDOG_EN
               else if (wdog == 5'd31) begin
                  err   <= 1'b1;
                  state <= ERR;
               end else begin
                  wdog <= wdog + 5'd1;
               end
`endif
            end
            OUT: begin
               // start is deliberately not looked at here, even on the
               // handshake cycle.
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
`ifdef MACS_CTRL_WDOG_EN
            ERR: begin
               state <= ERR;
            end
`endif
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
